// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Decoupled instruction-fetch stage. Holds the program counter, issues
// requests to instruction memory over a valid/ready channel, accepts in-order
// responses of any latency and buffers {instr, pc} pairs in a prefetch FIFO
// that feeds decode. A redirect flushes the FIFO, restarts fetch at the new
// address and marks every in-flight response as stale so it is discarded.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   redirect_valid     taken branch/jump this cycle
//   redirect_addr      new fetch PC (used unmodified)
//   imem_req_valid     request valid (credit-gated, combinational)
//   imem_req_ready     memory accepts request
//   imem_req_addr      request address (= current pc)
//   imem_rsp_valid     response valid, strictly in request order
//   imem_rsp_data      instruction word
//   out_valid          FIFO head valid to decode
//   out_ready          decode accepts head
//   out_instr, out_pc  head instruction and its PC
//   out_pc_next        out_pc + PC_STEP
//   fifo_count         occupied FIFO entries
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int          ADDR_W     = 32,
  parameter int          INSTR_W    = 32,
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int          PC_STEP    = 4,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            redirect_valid,
  input  logic [ADDR_W-1:0]               redirect_addr,
  output logic                            imem_req_valid,
  input  logic                            imem_req_ready,
  output logic [ADDR_W-1:0]               imem_req_addr,
  input  logic                            imem_rsp_valid,
  input  logic [INSTR_W-1:0]              imem_rsp_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [INSTR_W-1:0]              out_instr,
  output logic [ADDR_W-1:0]               out_pc,
  output logic [ADDR_W-1:0]               out_pc_next,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int                PTR_W      = $clog2(FIFO_DEPTH);
  localparam int                CNT_W      = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [CNT_W:0]    DEPTH      = (CNT_W+1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  rsp_pc;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   drop_cnt;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [INSTR_W-1:0] instr_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [FIFO_DEPTH];

  logic               credit_ok;
  logic               req_fire;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   outstanding_nxt;

  // Credit: every accepted request owns a FIFO slot, so a push can never
  // find the FIFO full.
  assign credit_ok      = ({1'b0, count} + {1'b0, outstanding}) < DEPTH;
  assign imem_req_valid = !rst && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc;

  assign out_valid   = (count != {CNT_W{1'b0}});
  assign out_instr   = instr_mem[rd_ptr];
  assign out_pc      = pc_mem[rd_ptr];
  assign out_pc_next = pc_mem[rd_ptr] + STEP;
  assign fifo_count  = count;

  // Handshake decode; redirect overrides both FIFO push and pop.
  always_comb begin
    req_fire        = imem_req_valid && imem_req_ready;
    push            = 1'b0;
    pop             = 1'b0;
    outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    if (redirect_valid) begin
      push = 1'b0;
      pop  = 1'b0;
    end else begin
      push = imem_rsp_valid && (drop_cnt == {CNT_W{1'b0}});
      pop  = out_valid && out_ready;
    end
  end

  // Control state: pc, rsp_pc, outstanding/drop counters and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_ADDR;
      rsp_pc      <= RESET_ADDR;
      outstanding <= {CNT_W{1'b0}};
      drop_cnt    <= {CNT_W{1'b0}};
      count       <= {CNT_W{1'b0}};
      rd_ptr      <= {PTR_W{1'b0}};
      wr_ptr      <= {PTR_W{1'b0}};
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        pc       <= redirect_addr;
        rsp_pc   <= redirect_addr;
        // Stale requests are already part of outstanding, so after a
        // redirect every still-pending response is stale; a response
        // arriving this cycle is itself discarded.
        drop_cnt <= outstanding - CNT_W'(imem_rsp_valid);
        count    <= {CNT_W{1'b0}};
        rd_ptr   <= {PTR_W{1'b0}};
        wr_ptr   <= {PTR_W{1'b0}};
      end else begin
        if (req_fire) begin
          pc <= pc + STEP;
        end else begin
          pc <= pc;
        end
        if (imem_rsp_valid && (drop_cnt != {CNT_W{1'b0}})) begin
          drop_cnt <= drop_cnt - CNT_W'(1);
        end else begin
          drop_cnt <= drop_cnt;
        end
        if (push) begin
          rsp_pc <= rsp_pc + STEP;
          wr_ptr <= wr_ptr + PTR_W'(1);
        end else begin
          rsp_pc <= rsp_pc;
          wr_ptr <= wr_ptr;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end else begin
          rd_ptr <= rd_ptr;
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // FIFO storage: data only, validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]    <= rsp_pc;
    end
  end

endmodule
